// File: rtl/subword_capture_fifo.sv
// ============================================================================
// Module      : subword_capture_fifo
// Description : Strobed capture of a transform sub-word into a show-ahead
//               FIFO with valid/ready output, change counter, overflow flag.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module subword_capture_fifo #(
    parameter int WD    = 4,
    parameter int DEPTH = 4,
    parameter int CNTW  = 8
) (
    input  logic                     CLK,
    input  logic                     RSTX,
    input  logic                     clr,
    input  logic                     sample_en,
    input  logic [WD-1:0]            din,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WD-1:0]            dout,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full,
    output logic                     overflow,
    output logic [CNTW-1:0]          chg_cnt
);

    localparam int c_AW = $clog2(DEPTH);
    localparam int c_LW = c_AW + 1;

    logic [WD-1:0]   mem_q [DEPTH];
    logic [WD-1:0]   mem_d [DEPTH];
    logic [c_AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [c_AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [c_LW-1:0] level_q, level_d;
    logic            overflow_q, overflow_d;
    logic [CNTW-1:0] chg_q, chg_d;
    logic            prev_valid_q, prev_valid_d;
    logic [WD-1:0]   prev_word_q, prev_word_d;

    logic            w_empty;
    logic            w_full;
    logic            w_pop;
    logic            w_push;
    logic [c_AW-1:0] w_last_ptr;

    assign w_empty    = (level_q == '0);
    assign w_full     = (level_q == c_LW'(DEPTH));
    assign w_pop      = ~w_empty & out_ready;
    assign w_push     = sample_en & (~w_full | w_pop);
    assign w_last_ptr = rd_ptr_q - c_AW'(1);

    always_comb begin
        mem_d        = mem_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        level_d      = level_q;
        overflow_d   = overflow_q;
        chg_d        = chg_q;
        prev_valid_d = prev_valid_q;
        prev_word_d  = prev_word_q;

        if (clr) begin
            // Collapse the read side onto the write side so dout keeps
            // showing the most recently written word while empty.
            rd_ptr_d     = wr_ptr_q;
            level_d      = '0;
            overflow_d   = 1'b0;
            chg_d        = '0;
            prev_valid_d = 1'b0;
        end else begin
            if (w_push) begin
                mem_d[wr_ptr_q] = din;
                wr_ptr_d        = wr_ptr_q + c_AW'(1);
                if (prev_valid_q && (din != prev_word_q) && (chg_q != {CNTW{1'b1}}))
                    chg_d = chg_q + CNTW'(1);
                prev_word_d  = din;
                prev_valid_d = 1'b1;
            end
            if (w_pop)
                rd_ptr_d = rd_ptr_q + c_AW'(1);
            if (w_push && !w_pop)
                level_d = level_q + c_LW'(1);
            else if (w_pop && !w_push)
                level_d = level_q - c_LW'(1);
            if (sample_en && w_full && !w_pop)
                overflow_d = 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge RSTX) begin
        if (!RSTX) begin
            for (int i = 0; i < DEPTH; i++)
                mem_q[i] <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            level_q      <= '0;
            overflow_q   <= 1'b0;
            chg_q        <= '0;
            prev_valid_q <= 1'b0;
            prev_word_q  <= '0;
        end else begin
            mem_q        <= mem_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            level_q      <= level_d;
            overflow_q   <= overflow_d;
            chg_q        <= chg_d;
            prev_valid_q <= prev_valid_d;
            prev_word_q  <= prev_word_d;
        end
    end

    assign out_valid = ~w_empty;
    assign dout      = w_empty ? mem_q[w_last_ptr] : mem_q[rd_ptr_q];
    assign level     = level_q;
    assign full      = w_full;
    assign overflow  = overflow_q;
    assign chg_cnt   = chg_q;

endmodule

`default_nettype wire

// File: tb/tb_subword_capture_fifo.sv
// ============================================================================
// Module      : tb_subword_capture_fifo
// Description : Scoreboard bench for subword_capture_fifo (CNTW=8 and CNTW=2).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_subword_capture_fifo;

    localparam int c_DEPTH = 4;

    logic       CLK = 1'b0;
    logic       RSTX = 1'b0;
    logic       clr = 1'b0;
    logic       sample_en = 1'b0;
    logic [3:0] din = '0;
    logic       out_ready = 1'b0;

    logic       out_valid, out_valid2;
    logic [3:0] dout, dout2;
    logic [2:0] level, level2;
    logic       full, full2;
    logic       overflow, overflow2;
    logic [7:0] chg_cnt;
    logic [1:0] chg_cnt2;

    subword_capture_fifo #(.WD(4), .DEPTH(c_DEPTH), .CNTW(8)) dut (
        .CLK(CLK), .RSTX(RSTX), .clr(clr), .sample_en(sample_en), .din(din),
        .out_valid(out_valid), .out_ready(out_ready), .dout(dout),
        .level(level), .full(full), .overflow(overflow), .chg_cnt(chg_cnt)
    );

    subword_capture_fifo #(.WD(4), .DEPTH(c_DEPTH), .CNTW(2)) dut2 (
        .CLK(CLK), .RSTX(RSTX), .clr(clr), .sample_en(sample_en), .din(din),
        .out_valid(out_valid2), .out_ready(out_ready), .dout(dout2),
        .level(level2), .full(full2), .overflow(overflow2), .chg_cnt(chg_cnt2)
    );

    always #5 CLK = ~CLK;

    // Reference model: queue of pending words plus flag/counter state.
    logic [3:0] exp_q[$];
    bit         m_ovf;
    int         m_chg;
    int         m_chg2;
    bit         m_prev_v;
    logic [3:0] m_prev_w;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_ovf = 0; m_chg = 0; m_chg2 = 0; m_prev_v = 0; m_prev_w = '0;
    endtask

    task automatic check_state();
        chk("level", 32'(level), 32'(exp_q.size()));
        chk("full", 32'(full), 32'(exp_q.size() == c_DEPTH));
        chk("overflow", 32'(overflow), 32'(m_ovf));
        chk("chg_cnt", 32'(chg_cnt), 32'(m_chg));
        chk("chg_cnt_w2", 32'(chg_cnt2), 32'(m_chg2));
        chk("level_w2", 32'(level2), 32'(exp_q.size()));
        if (exp_q.size() > 0) chk("dout_head", 32'(dout), 32'(exp_q[0]));
    endtask

    // Monitor: a pop happens at the coming edge when valid & ready & ~clr.
    always @(negedge CLK) begin
        if (RSTX) begin
            chk("out_valid", 32'(out_valid), 32'(exp_q.size() > 0));
            if (out_valid && out_ready && !clr) begin
                if (exp_q.size() == 0) begin
                    chk("pop_on_empty_model", 32'(1), 32'(0));
                end else begin
                    chk("dout_pop", 32'(dout), 32'(exp_q[0]));
                    void'(exp_q.pop_front());
                end
            end
        end
    end

    // Called at posedge+1: drives one cycle, then applies the model after the edge.
    task automatic step(input bit se, input logic [3:0] d, input bit rdy, input bit c);
        int  sz;
        bit  pop, push, drop;
        sample_en = se; din = d; out_ready = rdy; clr = c;
        sz   = exp_q.size();
        pop  = rdy && (sz > 0) && !c;
        push = se && !c && ((sz < c_DEPTH) || pop);
        drop = se && !c && (sz == c_DEPTH) && !pop;
        @(posedge CLK); #1;
        if (c) begin
            model_reset();
        end else begin
            if (push) begin
                if (m_prev_v && d != m_prev_w) begin
                    if (m_chg < 255) m_chg++;
                    if (m_chg2 < 3) m_chg2++;
                end
                m_prev_v = 1; m_prev_w = d;
                exp_q.push_back(d);
            end
            if (drop) m_ovf = 1;
        end
        sample_en = 0; out_ready = 0; clr = 0;
        check_state();
    endtask

    initial begin
        model_reset();
        #12;
        chk("rst_level", 32'(level), 32'(0));
        chk("rst_valid", 32'(out_valid), 32'(0));
        chk("rst_dout", 32'(dout), 32'(0));
        chk("rst_chg", 32'(chg_cnt), 32'(0));
        @(posedge CLK); #1;
        RSTX = 1'b1;
        @(posedge CLK); #1;

        // Fill with a duplicate, then a change, then overflow.
        step(1, 4'h3, 0, 0);
        step(1, 4'h3, 0, 0);
        step(1, 4'hA, 0, 0);
        chk("tp1_level", 32'(level), 32'(3));
        chk("tp1_chg", 32'(chg_cnt), 32'(1));
        step(1, 4'h5, 0, 0);
        step(1, 4'hC, 0, 0);
        chk("tp2_ovf", 32'(overflow), 32'(1));
        chk("tp2_chg", 32'(chg_cnt), 32'(2));
        // Push and pop together while full.
        step(1, 4'h7, 1, 0);
        chk("tp3_level", 32'(level), 32'(4));
        chk("tp3_dout", 32'(dout), 32'(4'h3));
        // Drain plus extra ready cycles on empty.
        for (int i = 0; i < 6; i++) step(0, 4'h0, 1, 0);
        chk("tp4_level", 32'(level), 32'(0));

        // Alternating pattern saturates the narrow counter.
        for (int i = 0; i < 6; i++) step(1, (i % 2) ? 4'hF : 4'h0, 1, 0);
        chk("tp5_chg2", 32'(chg_cnt2), 32'(3));
        for (int i = 0; i < 4; i++) step(0, 4'h0, 1, 0);

        // Clear with a concurrent sample while level=2 and overflow set.
        for (int i = 0; i < 5; i++) step(1, 4'(i), 0, 0);
        step(0, 4'h0, 1, 0);
        step(0, 4'h0, 1, 0);
        step(1, 4'h9, 0, 1);
        chk("tp6_level", 32'(level), 32'(0));
        chk("tp6_ovf", 32'(overflow), 32'(0));
        step(1, 4'hE, 0, 0);
        chk("tp6_chg", 32'(chg_cnt), 32'(0));
        step(0, 4'h0, 1, 0);

        // Asynchronous reset between edges with level=3.
        step(1, 4'h1, 0, 0);
        step(1, 4'h2, 0, 0);
        step(1, 4'h4, 0, 0);
        #2 RSTX = 1'b0;
        #1;
        chk("arst_valid", 32'(out_valid), 32'(0));
        chk("arst_level", 32'(level), 32'(0));
        chk("arst_chg", 32'(chg_cnt), 32'(0));
        model_reset();
        @(posedge CLK); #1;
        RSTX = 1'b1;
        @(posedge CLK); #1;

        // Randomized traffic.
        for (int i = 0; i < 400; i++)
            step(($urandom_range(0, 99) < 60), 4'($urandom_range(0, 15)),
                 ($urandom_range(0, 99) < 45), ($urandom_range(0, 99) < 3));
        for (int i = 0; i < 6; i++) step(0, 4'h0, 1, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
